// File: rtl/rv523_uart_pkg.sv
// Shared UART encodings for the RV523 serial link.
// The state enum is shared with the receive side.
package rv523_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period down-counter.
// Raises tick for one cycle every CLKS_PER_BIT cycles; reload restarts a full bit period.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;

  // Wraps on its own at zero, so every bit boundary is also a reload point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (reload || (cnt_reg == '0)) begin
      cnt_reg <= CNT_MAX;
    end else begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign tick = (cnt_reg == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: START, DATA_BITS data bits LSB first, optional even parity, STOP.
// Define UART_TX_PARITY_EN to insert the parity bit after the data bits.
module uart_tx_serializer
  import rv523_uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [DATA_BITS-1:0] TX_DATA,
  input  logic                 TX_VALID,
  output logic                 TX_READY,
  output logic                 TXD,
  output logic                 BUSY
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  uart_state_e          state_reg;
  logic [DATA_BITS-1:0] shreg_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic [IDX_W-1:0]     bit_idx_reg;
  logic                 tx_ready_reg;
  logic                 busy_reg;
  logic                 txd_reg;
  logic                 accept;
  logic                 tick;
`ifdef UART_TX_PARITY_EN
  logic                 parity_reg;
`endif

  assign accept = TX_VALID && tx_ready_reg;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (CLK),
    .rst_n (nRST),
    .reload(accept),
    .tick  (tick)
  );

  genvar gi;
  generate
    for (gi = 0; gi < DATA_BITS - 1; gi++) begin : g_shift
      assign shift_next[gi] = shreg_reg[gi+1];
    end
  endgenerate
  assign shift_next[DATA_BITS-1] = 1'b0;

  // bit_idx_reg counts data bits in DATA and stop bits in STOP.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg    <= IDLE;
      shreg_reg    <= '0;
      bit_idx_reg  <= '0;
      tx_ready_reg <= 1'b1;
      busy_reg     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            shreg_reg    <= TX_DATA;
            bit_idx_reg  <= '0;
            state_reg    <= START;
            tx_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
          end
        end
        START: begin
          if (tick) begin
            state_reg   <= DATA;
            bit_idx_reg <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            shreg_reg <= shift_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_reg ^ shreg_reg[0];
`endif
            if (bit_idx_reg == LAST_BIT) begin
              bit_idx_reg <= '0;
`ifdef UART_TX_PARITY_EN
              state_reg   <= PARITY;
`else
              state_reg   <= STOP;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state_reg   <= STOP;
            bit_idx_reg <= '0;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (bit_idx_reg == LAST_STOP) begin
              bit_idx_reg  <= '0;
              state_reg    <= IDLE;
              tx_ready_reg <= 1'b1;
              busy_reg     <= 1'b0;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg    <= IDLE;
          tx_ready_reg <= 1'b1;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  // Line follows the state one cycle later, so the start bit appears the edge after accept.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      txd_reg <= UART_IDLE_LEVEL;
    end else begin
      case (state_reg)
        START:   txd_reg <= ~UART_IDLE_LEVEL;
        DATA:    txd_reg <= shreg_reg[0];
`ifdef UART_TX_PARITY_EN
        PARITY:  txd_reg <= parity_reg;
`endif
        default: txd_reg <= UART_IDLE_LEVEL;
      endcase
    end
  end

  assign TXD      = txd_reg;
  assign TX_READY = tx_ready_reg;
  assign BUSY     = busy_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomized self-checking bench for uart_tx_serializer against a frame-level line model.
// Honours UART_TX_PARITY_EN for the expected frame layout.
module tb_uart_tx_serializer;

  localparam int CPB = 4;
  localparam int DB  = 8;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NSLOTS    = 1 + DB + P + SB;
  localparam int FRAME_CYC = NSLOTS * CPB;
  localparam int LOG_N     = 256;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_VALID = 1'b0;
  logic       TX_READY;
  logic       TXD;
  logic       BUSY;

  int total = 0;
  int bad   = 0;

  logic txd_log   [LOG_N];
  logic ready_log [LOG_N];
  logic busy_log  [LOG_N];

  always #5 CLK = ~CLK;

  uart_tx_serializer #(
    .DATA_BITS(DB),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS(SB)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .TX_DATA (TX_DATA),
    .TX_VALID(TX_VALID),
    .TX_READY(TX_READY),
    .TXD     (TXD),
    .BUSY    (BUSY)
  );

  // Serial slot k of a frame: 0 = start, 1..DB = data LSB first, then parity, then stop.
  function automatic logic frame_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= DB) return b[slot-1];
    if (P == 1 && slot == DB + 1) return ^b;
    return 1'b1;
  endfunction

  // Line level rel cycles after the accepting edge (the start bit shows from rel=1).
  function automatic logic line_level(input logic [7:0] b, input int rel);
    if (rel < 1 || rel > FRAME_CYC) return 1'b1;
    return frame_bit(b, (rel - 1) / CPB);
  endfunction

  // Ready drops on the accepting edge and returns FRAME_CYC edges later.
  function automatic logic ready_level(input int rel);
    return !(rel >= 0 && rel < FRAME_CYC);
  endfunction

  task automatic start_tx(input logic [7:0] b, input bit keep);
    int waited = 0;
    @(negedge CLK);
    while (TX_READY !== 1'b1 && waited < 200) begin
      @(negedge CLK);
      waited++;
    end
    total++;
    if (TX_READY !== 1'b1) begin
      bad++;
      $display("FAIL start_wait: TX_READY=%b after %0d cycles, required 1", TX_READY, waited);
    end
    TX_DATA  = b;
    TX_VALID = 1'b1;
    @(posedge CLK);
    #1;
    if (!keep) TX_VALID = 1'b0;
  endtask

  // Logs outputs after edges n+0 .. n+ncyc-1 (n = accepting edge) and disturbs the inputs.
  task automatic capture(input int ncyc, input int toggle_until, input int drop_at,
                         input logic [7:0] next_data);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge CLK);
      txd_log[c]   = TXD;
      ready_log[c] = TX_READY;
      busy_log[c]  = BUSY;
      if (c == 1) TX_DATA = next_data;
      if (c < toggle_until) begin
        TX_DATA  = 8'($urandom);
        TX_VALID = 1'b1;
      end else if (c == toggle_until && toggle_until > 0) begin
        TX_VALID = 1'b0;
      end
      if (c == drop_at) TX_VALID = 1'b0;
    end
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    TX_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    total++;
    if ({TXD, TX_READY, BUSY} !== 3'b110) begin
      bad++;
      $display("FAIL reset_assert: {TXD,READY,BUSY}=%b required 110", {TXD, TX_READY, BUSY});
    end
    nRST = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      total++;
      if ({TXD, TX_READY, BUSY} !== 3'b110) begin
        bad++;
        $display("FAIL reset_idle c=%0d: {TXD,READY,BUSY}=%b required 110", c, {TXD, TX_READY, BUSY});
      end
    end
    $display("reset: idle held 100 cycles");
  endtask

  task automatic test_single;
    int low_cnt = 0;
    start_tx(8'hA5, 1'b0);
    capture(FRAME_CYC + 4, 0, -1, 8'hA5);
    for (int c = 0; c < FRAME_CYC + 4; c++) begin
      total++;
      if (txd_log[c] !== line_level(8'hA5, c)) begin
        bad++;
        $display("FAIL single_txd c=%0d: TXD=%b required %b", c, txd_log[c], line_level(8'hA5, c));
      end
      total++;
      if ({ready_log[c], busy_log[c]} !== {ready_level(c), !ready_level(c)}) begin
        bad++;
        $display("FAIL single_ready c=%0d: READY/BUSY=%b%b required %b%b", c, ready_log[c],
                 busy_log[c], ready_level(c), !ready_level(c));
      end
      if (ready_log[c] === 1'b0) low_cnt++;
    end
    total++;
    if (low_cnt != 40) begin
      bad++;
      $display("FAIL single_ready_len: TX_READY low %0d cycles, required 40", low_cnt);
    end
    $display("single: byte=a5 ready_low=%0d", low_cnt);
  endtask

  task automatic test_back_to_back;
    int ncyc = 2 * FRAME_CYC + 4;
    int off  = FRAME_CYC + 1;
    int first_fall = -1;
    int second_fall = -1;
    int extra_accepts = 0;
    logic exp_txd, exp_rdy;
    start_tx(8'h00, 1'b1);
    capture(ncyc, 0, off, 8'hFF);
    for (int c = 0; c < ncyc; c++) begin
      exp_txd = line_level(8'h00, c) & line_level(8'hFF, c - off);
      exp_rdy = ready_level(c) & ready_level(c - off);
      total++;
      if (txd_log[c] !== exp_txd) begin
        bad++;
        $display("FAIL b2b_txd c=%0d: TXD=%b required %b", c, txd_log[c], exp_txd);
      end
      total++;
      if ({ready_log[c], busy_log[c]} !== {exp_rdy, !exp_rdy}) begin
        bad++;
        $display("FAIL b2b_ready c=%0d: READY/BUSY=%b%b required %b%b", c, ready_log[c],
                 busy_log[c], exp_rdy, !exp_rdy);
      end
      if (c > 0) begin
        if (txd_log[c-1] === 1'b1 && txd_log[c] === 1'b0) begin
          if (first_fall < 0) first_fall = c;
          else if (second_fall < 0) second_fall = c;
        end
        if (ready_log[c-1] === 1'b1 && ready_log[c] === 1'b0) extra_accepts++;
      end
    end
    total++;
    if (second_fall - first_fall != 41) begin
      bad++;
      $display("FAIL b2b_spacing: start bits %0d cycles apart, required 41", second_fall - first_fall);
    end
    total++;
    if (extra_accepts != 1) begin
      bad++;
      $display("FAIL b2b_accepts: %0d accepts, required 2", extra_accepts + 1);
    end
    $display("back_to_back: 00 then ff spacing=%0d accepts=%0d", second_fall - first_fall, extra_accepts + 1);
  endtask

  task automatic test_busy_holdoff;
    logic [7:0] b;
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      start_tx(b, 1'b0);
      capture(FRAME_CYC + 3, FRAME_CYC, -1, 8'($urandom));
      for (int c = 0; c < FRAME_CYC + 3; c++) begin
        total++;
        if (txd_log[c] !== line_level(b, c)) begin
          bad++;
          $display("FAIL holdoff_txd byte=%h c=%0d: TXD=%b required %b", b, c, txd_log[c], line_level(b, c));
        end
        total++;
        if (ready_log[c] !== ready_level(c)) begin
          bad++;
          $display("FAIL holdoff_ready byte=%h c=%0d: READY=%b required %b", b, c, ready_log[c], ready_level(c));
        end
      end
      $display("busy_holdoff: byte=%h sent with toggling TX_DATA", b);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b;
    int cut;
    for (int k = 0; k < 5; k++) begin
      b   = (k == 0) ? 8'h0F : 8'($urandom);
      cut = (k == 0) ? 18 : int'($urandom_range(1, FRAME_CYC - 1));
      start_tx(b, 1'b0);
      repeat (cut + 1) @(negedge CLK);
      #2;
      nRST = 1'b0;
      #1;
      total++;
      if ({TXD, TX_READY, BUSY} !== 3'b110) begin
        bad++;
        $display("FAIL midreset byte=%h cut=%0d: {TXD,READY,BUSY}=%b required 110", b, cut,
                 {TXD, TX_READY, BUSY});
      end
      @(negedge CLK);
      nRST = 1'b1;
      $display("reset_mid_frame: byte=%h aborted at cycle %0d", b, cut);
    end
    start_tx(8'h55, 1'b0);
    capture(FRAME_CYC + 2, 0, -1, 8'hAA);
    for (int c = 0; c < FRAME_CYC + 2; c++) begin
      total++;
      if (txd_log[c] !== line_level(8'h55, c)) begin
        bad++;
        $display("FAIL after_reset_txd c=%0d: TXD=%b required %b", c, txd_log[c], line_level(8'h55, c));
      end
      total++;
      if (ready_log[c] !== ready_level(c)) begin
        bad++;
        $display("FAIL after_reset_ready c=%0d: READY=%b required %b", c, ready_log[c], ready_level(c));
      end
    end
    $display("reset_mid_frame: clean frame 55 after reset");
  endtask

  task automatic test_random;
    logic [7:0] b;
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 5)) @(negedge CLK);
      b = 8'($urandom);
      start_tx(b, 1'b0);
      capture(FRAME_CYC + 2, 0, -1, 8'($urandom));
      for (int c = 0; c < FRAME_CYC + 2; c++) begin
        total++;
        if (txd_log[c] !== line_level(b, c)) begin
          bad++;
          $display("FAIL random_txd byte=%h c=%0d: TXD=%b required %b", b, c, txd_log[c], line_level(b, c));
        end
        total++;
        if ({ready_log[c], busy_log[c]} !== {ready_level(c), !ready_level(c)}) begin
          bad++;
          $display("FAIL random_ready byte=%h c=%0d: READY/BUSY=%b%b", b, c, ready_log[c], busy_log[c]);
        end
      end
      $display("random: byte=%h", b);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic [7:0] bytes [2];
    logic       par_exp [2];
    int         par_c;
    int         low_cnt;
    bytes[0] = 8'h07; par_exp[0] = 1'b1;
    bytes[1] = 8'h03; par_exp[1] = 1'b0;
    par_c = 1 + (DB + 1) * CPB + CPB / 2;
    for (int k = 0; k < 2; k++) begin
      low_cnt = 0;
      start_tx(bytes[k], 1'b0);
      capture(FRAME_CYC + 2, 0, -1, 8'h00);
      for (int c = 0; c < FRAME_CYC + 2; c++) begin
        total++;
        if (txd_log[c] !== line_level(bytes[k], c)) begin
          bad++;
          $display("FAIL parity_txd byte=%h c=%0d: TXD=%b required %b", bytes[k], c, txd_log[c],
                   line_level(bytes[k], c));
        end
        if (ready_log[c] === 1'b0) low_cnt++;
      end
      total++;
      if (txd_log[par_c] !== par_exp[k]) begin
        bad++;
        $display("FAIL parity_bit byte=%h: got %b required %b", bytes[k], txd_log[par_c], par_exp[k]);
      end
      total++;
      if (low_cnt != 44) begin
        bad++;
        $display("FAIL parity_len byte=%h: TX_READY low %0d cycles, required 44", bytes[k], low_cnt);
      end
      $display("parity: byte=%h parity=%b", bytes[k], txd_log[par_c]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_holdoff();
    test_reset_mid_frame();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
